// File: rtl/pc_redirect_unit.sv
// Fetch PC sequencer: sequential advance, one-cycle branch/exception redirect,
// and a HOLD state that parks a redirect until the fetch can advance.
module pc_redirect_unit #(
    parameter logic [31:0] RESET_PC   = 32'h0040_0000,
    parameter logic [31:0] EXC_VECTOR = 32'h0040_0004
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall_in,
    input  logic        is_branch,
    input  logic [31:0] branch_target,
    input  logic        exception,
    input  logic        imem_ready,
    output logic [31:0] pc,
    output logic        fetch_req,
    output logic        flush_out,
    output logic        redirect_pending
);

    localparam logic [31:0] RESET_PC_AL = {RESET_PC[31:2], 2'b00};
    localparam logic [31:0] EXC_PC_AL   = {EXC_VECTOR[31:2], 2'b00};

    typedef enum logic {RUN, HOLD} state_t;

    state_t      state, state_next;
    logic [31:0] pend_target, pend_next;
    logic        pend_exc, pend_exc_next;
    logic [31:0] pc_next;
    logic        flush_next;
    logic        advance;

    assign advance = imem_ready && !stall_in;

    always_ff @(posedge clk) begin
        if (rst) begin
            state            <= RUN;
            pc               <= RESET_PC_AL;
            pend_target      <= '0;
            pend_exc         <= 1'b0;
            fetch_req        <= 1'b0;
            flush_out        <= 1'b0;
            redirect_pending <= 1'b0;
        end else begin
            state            <= state_next;
            pc               <= pc_next;
            pend_target      <= pend_next;
            pend_exc         <= pend_exc_next;
            fetch_req        <= 1'b1;
            flush_out        <= flush_next;
            redirect_pending <= (state_next == HOLD);
        end
    end

    always_comb begin
        state_next    = state;
        pc_next       = pc;
        pend_next     = pend_target;
        pend_exc_next = pend_exc;
        flush_next    = 1'b0;
        case (state)
            RUN: begin
                if (advance) begin
                    if (exception) begin
                        pc_next    = EXC_PC_AL;
                        flush_next = 1'b1;
                    end else if (is_branch) begin
                        pc_next = {branch_target[31:2], 2'b00};
                    end else begin
                        pc_next = pc + 32'd4;
                    end
                end else if (exception) begin
                    pend_next     = EXC_PC_AL;
                    pend_exc_next = 1'b1;
                    state_next    = HOLD;
                end else if (is_branch && !stall_in) begin
                    pend_next     = {branch_target[31:2], 2'b00};
                    pend_exc_next = 1'b0;
                    state_next    = HOLD;
                end
            end
            HOLD: begin
                // exception overrides the parked target even in the advance cycle
                if (exception) begin
                    pend_next     = EXC_PC_AL;
                    pend_exc_next = 1'b1;
                end
                if (advance) begin
                    pc_next    = pend_next;
                    flush_next = pend_exc_next;
                    state_next = RUN;
                end
            end
            default: state_next = RUN;
        endcase
    end

endmodule
